// File: rtl/sub16s.sv
// Bit-serial subtractor: computes x - y - bin one bit per clock, LSB first,
// and reports the difference with borrow, signed-overflow and zero flags.
module sub16s #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] xSh_q;
  logic [WIDTH-1:0] ySh_q;
  logic [WIDTH-1:0] acc_q;
  logic             borrow_q;

  logic             dBit;
  logic             borrow_d;
  logic [WIDTH-1:0] acc_d;
  logic             lastBit;

  // One full-subtractor cell; the partial difference fills from the top so
  // that after the last bit it is already in natural order.
  always_comb begin
    dBit     = xSh_q[0] ^ ySh_q[0] ^ borrow_q;
    borrow_d = (~xSh_q[0] & ySh_q[0]) | (~(xSh_q[0] ^ ySh_q[0]) & borrow_q);
    acc_d    = {dBit, acc_q[WIDTH-1:1]};
    lastBit  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xSh_q    <= '0;
      ySh_q    <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xSh_q    <= x;
            ySh_q    <= y;
            borrow_q <= bin;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          xSh_q    <= xSh_q >> 1;
          ySh_q    <= ySh_q >> 1;
          borrow_q <= borrow_d;
          acc_q    <= acc_d;
          cnt_q    <= cnt_q + CW'(1);
          // On the sign bit the shift registers still hold x and y MSBs.
          if (lastBit) begin
            diff    <= acc_d;
            bout    <= borrow_d;
            ovf     <= (xSh_q[0] ^ ySh_q[0]) & (dBit ^ xSh_q[0]);
            zero    <= (acc_d == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            xSh_q    <= x;
            ySh_q    <= y;
            borrow_q <= bin;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16s.sv
// Directed self-checking bench for sub16s: reset, flag vectors, ignored
// start, reset abort and back-to-back operation with held start.
module tb_sub16s;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int errors;
  int checks;

  sub16s #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepts one operation, scrambles the operand inputs afterwards and waits
  // (bounded) for done; lat is the edge count after acceptance, or -1.
  task automatic runOp(input logic [15:0] xv, input logic [15:0] yv,
                       input logic bv, output int lat);
    x = xv;
    y = yv;
    bin = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    bin = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1;
    x = 16'h1234;
    y = 16'h0001;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: diff=%h bout=%b ovf=%b zero=%b, expected 0000 0 0 0",
               diff, bout, ovf, zero);
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_basic;
    int lat;
    runOp(16'h1234, 16'h0234, 1'b0, lat);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges, expected 16", lat);
    end
    checks++;
    if (diff !== 16'h1000 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: diff=%h bout=%b ovf=%b zero=%b busy=%b, expected 1000 0 0 0 0",
               diff, bout, ovf, zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || diff !== 16'h1000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_hold: done=%b diff=%h busy=%b, expected 0 1000 0", done, diff, busy);
    end
  endtask

  task automatic test_flags;
    logic [15:0] xv [5];
    logic [15:0] yv [5];
    logic        bv [5];
    logic [15:0] ed [5];
    logic        eb [5];
    logic        eo [5];
    logic        ez [5];
    int lat;
    xv = '{16'h0000, 16'h8000, 16'h0005, 16'h0005, 16'h7FFF};
    yv = '{16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'hFFFF};
    bv = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    ed = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
    eb = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1};
    eo = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
    ez = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 5; i++) begin
      runOp(xv[i], yv[i], bv[i], lat);
      checks++;
      if (lat !== 16 || diff !== ed[i] || bout !== eb[i] || ovf !== eo[i] || zero !== ez[i]) begin
        errors++;
        $display("[TB] FAIL flags_vec%0d: lat=%0d diff=%h bout=%b ovf=%b zero=%b, expected 16 %h %b %b %b",
                 i, lat, diff, bout, ovf, zero, ed[i], eb[i], eo[i], ez[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat;
    x = 16'd100;
    y = 16'd200;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        x = 16'd7;
        y = 16'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 16 || diff !== 16'hFF9C || bout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignore_start_result: lat=%0d diff=%h bout=%b, expected 16 ff9c 1",
               lat, diff, bout);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_start_no_second: busy=%b done=%b, expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || diff !== 16'hFF9C) begin
      errors++;
      $display("[TB] FAIL ignore_start_idle: busy=%b diff=%h, expected 0 ff9c", busy, diff);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen;
    x = 16'h00FF;
    y = 16'h0001;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_running: busy=%b, expected 1", busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 ||
        ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_cleared: busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, expected all 0",
               busy, done, diff, bout, ovf, zero);
    end
    seen = 0;
    start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: %0d cycles with busy/done during reset, expected 0", seen);
    end
    reset = 1'b1;
    runOp(16'h0003, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== 16 || diff !== 16'h0002 || bout !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_restart: lat=%0d diff=%h bout=%b zero=%b, expected 16 0002 0 0",
               lat, diff, bout, zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] xs [80];
    logic [15:0] ys [80];
    logic        bs [80];
    logic [16:0] expv;
    int nDone;
    int lastDone;
    int acc;
    nDone = 0;
    lastDone = -1;
    start = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      xs[cyc] = 16'(cyc * 16'h0123 + 5);
      ys[cyc] = 16'(cyc * 16'h0457);
      bs[cyc] = 1'(cyc);
      x = xs[cyc];
      y = ys[cyc];
      bin = bs[cyc];
      @(posedge clk); #1;
      if (done) begin
        acc = cyc - 16;
        checks++;
        if (acc < 0 || (lastDone >= 0 && cyc - lastDone != 17) || (lastDone < 0 && cyc != 16)) begin
          errors++;
          $display("[TB] FAIL b2b_spacing: done at cycle %0d, previous %0d, expected first at 16 then every 17",
                   cyc, lastDone);
        end else begin
          expv = {1'b0, xs[acc]} - {1'b0, ys[acc]} - {16'h0000, bs[acc]};
          checks++;
          if (diff !== expv[15:0] || bout !== expv[16]) begin
            errors++;
            $display("[TB] FAIL b2b_op%0d: diff=%h bout=%b, expected %h %b",
                     nDone, diff, bout, expv[15:0], expv[16]);
          end
        end
        lastDone = cyc;
        nDone++;
      end
    end
    start = 1'b0;
    checks++;
    if (nDone !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: %0d completions, expected 4", nDone);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    bin = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_flags();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
